// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - execute-stage to divider handshake and HI/LO write port bundle
interface div_unit_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic [1:0]  w_hilo_ena;
    logic [31:0] w_hi_data;
    logic [31:0] w_lo_data;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  busy, w_hilo_ena, w_hi_data, w_lo_data
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output busy, w_hilo_ena, w_hi_data, w_lo_data
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring radix-2 32-bit DIV/DIVU with one-cycle HI/LO write
module div_unit (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  dif
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] rem, quo, dvs_mag, dividend_raw;
    logic [4:0]  cnt;
    logic        quo_neg, rem_neg, div_zero;
    logic        load;
    logic [31:0] dvd_abs, dvs_abs;
    logic [32:0] partial, trial;

    assign dvd_abs = (dif.is_signed && dif.dividend[31]) ? -dif.dividend : dif.dividend;
    assign dvs_abs = (dif.is_signed && dif.divisor[31])  ? -dif.divisor  : dif.divisor;
    assign partial = {rem, quo[31]};
    assign trial   = partial - {1'b0, dvs_mag};
    assign dif.busy = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        load           = 1'b0;
        dif.w_hilo_ena = 2'b00;
        dif.w_hi_data  = 32'd0;
        dif.w_lo_data  = 32'd0;
        case (state)
            IDLE: begin
                if (dif.start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                dif.w_hilo_ena = 2'b11;
                if (div_zero) begin
                    dif.w_hi_data = dividend_raw;
                    dif.w_lo_data = 32'hFFFF_FFFF;
                end else begin
                    dif.w_hi_data = rem_neg ? -rem : rem;
                    dif.w_lo_data = quo_neg ? -quo : quo;
                end
                // back-to-back issue: a new start is taken on the write cycle
                if (dif.start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (dif.cancel) begin
            state_nxt      = IDLE;
            load           = 1'b0;
            dif.w_hilo_ena = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rem          <= 32'd0;
            quo          <= 32'd0;
            dvs_mag      <= 32'd0;
            dividend_raw <= 32'd0;
            cnt          <= 5'd0;
            quo_neg      <= 1'b0;
            rem_neg      <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                rem          <= 32'd0;
                quo          <= dvd_abs;
                dvs_mag      <= dvs_abs;
                dividend_raw <= dif.dividend;
                quo_neg      <= dif.is_signed & (dif.dividend[31] ^ dif.divisor[31]);
                rem_neg      <= dif.is_signed & dif.dividend[31];
                div_zero     <= (dif.divisor == 32'd0);
                cnt          <= 5'd0;
            end else if (state == CALC) begin
                if (!trial[32]) begin
                    rem <= trial[31:0];
                    quo <= {quo[30:0], 1'b1};
                end else begin
                    rem <= partial[31:0];
                    quo <= {quo[30:0], 1'b0};
                end
                cnt <= cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    div_unit_if dif();

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        int sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        dif.dividend  = a;
        dif.divisor   = b;
        dif.is_signed = s;
        dif.start     = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        check("busy_after_start", {31'd0, dif.busy}, 32'd1);
    endtask

    // Counts cycles until the write strobe; leaves the caller at the DONE-cycle negedge.
    task automatic wait_result(input string tag, input int exp_n,
                               input logic [31:0] a, input logic [31:0] b, input logic s);
        int n = 0;
        int low_busy = 0;
        logic [63:0] exp;
        exp = model(a, b, s);
        do begin
            @(negedge clk);
            n++;
            if (dif.busy !== 1'b1) low_busy++;
        end while (dif.w_hilo_ena === 2'b00 && n < 100);
        check({tag, "_latency"}, 32'(n), 32'(exp_n));
        check({tag, "_busy_held"}, 32'(low_busy), 32'd0);
        check({tag, "_ena"}, {30'd0, dif.w_hilo_ena}, 32'd3);
        check({tag, "_hi"}, dif.w_hi_data, exp[63:32]);
        check({tag, "_lo"}, dif.w_lo_data, exp[31:0]);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, dif.busy}, 32'd0);
        check({tag, "_idle_ena"}, {30'd0, dif.w_hilo_ena}, 32'd0);
        check({tag, "_idle_hi"}, dif.w_hi_data, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
        issue(a, b, s);
        wait_result(tag, 32, a, b, s);
        idle_check(tag);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          bad;

        dif.start = 1'b0; dif.is_signed = 1'b0; dif.cancel = 1'b0;
        dif.dividend = 32'd0; dif.divisor = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        check("rst_ena", {30'd0, dif.w_hilo_ena}, 32'd0);
        check("rst_hi", dif.w_hi_data, 32'd0);
        check("rst_lo", dif.w_lo_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("divu_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_zero", 32'h1234_5678, 32'd0, 1'b0);
        run_op("div_zero", 32'hFFFF_FF00, 32'd0, 1'b1);
        run_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);

        // cancel together with start in IDLE wins
        dif.cancel = 1'b1;
        dif.start  = 1'b1;
        @(negedge clk);
        dif.start  = 1'b0;
        dif.cancel = 1'b0;
        check("cancel_vs_start_busy", {31'd0, dif.busy}, 32'd0);

        // cancel on the 10th CALC cycle
        issue(32'd1000, 32'd3, 1'b0);
        bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (dif.w_hilo_ena !== 2'b00) bad++;
        end
        dif.cancel = 1'b1;
        @(negedge clk);
        dif.cancel = 1'b0;
        check("cancel_busy_low", {31'd0, dif.busy}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (dif.w_hilo_ena !== 2'b00) bad++;
        end
        check("cancel_no_write", 32'(bad), 32'd0);
        run_op("after_cancel", 32'd1000, 32'd3, 1'b0);

        // cancel during DONE suppresses the write combinationally
        issue(32'd55, 32'd5, 1'b0);
        wait_result("done_cancel", 32, 32'd55, 32'd5, 1'b0);
        dif.cancel = 1'b1;
        #1;
        check("done_cancel_ena", {30'd0, dif.w_hilo_ena}, 32'd0);
        @(negedge clk);
        dif.cancel = 1'b0;
        check("done_cancel_busy", {31'd0, dif.busy}, 32'd0);

        // start re-pulsed mid-CALC is ignored
        issue(32'd12345, 32'd10, 1'b0);
        repeat (3) @(negedge clk);
        dif.dividend = 32'd999; dif.divisor = 32'd4; dif.is_signed = 1'b1; dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        wait_result("repulse", 28, 32'd12345, 32'd10, 1'b0);
        idle_check("repulse");

        // back-to-back issue on the DONE cycle
        issue(32'd77, 32'd8, 1'b0);
        wait_result("b2b_first", 32, 32'd77, 32'd8, 1'b0);
        issue(32'hFFFF_FF9C, 32'd9, 1'b1);
        wait_result("b2b_second", 32, 32'hFFFF_FF9C, 32'd9, 1'b1);
        idle_check("b2b");

        // asynchronous reset mid-CALC
        issue(32'd500, 32'd6, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, dif.busy}, 32'd0);
        check("arst_ena", {30'd0, dif.w_hilo_ena}, 32'd0);
        check("arst_lo", dif.w_lo_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.w_hilo_ena !== 2'b00 || dif.busy !== 1'b0) bad++;
        end
        check("arst_no_write", 32'(bad), 32'd0);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 300);
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = $urandom;
                3: b = -$urandom_range(1, 20);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), a, b, s);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
